// File: rtl/systema_irq_ctrl_pkg.sv
// systema_irq_ctrl_pkg: shared register map, FSM encoding and widths for the systema interrupt controller
package systema_irq_ctrl_pkg;
  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_PENDING = 3'd1;
  localparam logic [2:0] ADDR_ENABLE  = 3'd2;
  localparam logic [2:0] ADDR_TRIGGER = 3'd3;
  localparam logic [2:0] ADDR_VECTOR  = 3'd4;
  localparam logic [2:0] ADDR_EOI     = 3'd5;
  localparam logic [2:0] ADDR_CTRL    = 3'd6;
  localparam int VEC_VALID_BIT = 15;
  localparam int ID_W = 4;
  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SERVICE} state_t;
endpackage

// File: rtl/systema_irq_ctrl_if.sv
// systema_irq_ctrl_if: 16-bit, 3-bit-address Avalon-MM slave bus shared with the systema peripherals
interface systema_irq_ctrl_if;
  logic        chipselect;
  logic [2:0]  address;
  logic        read_n;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  modport master (output chipselect, address, read_n, write_n, writedata, input readdata);
  modport slave (input chipselect, address, read_n, write_n, writedata, output readdata);
endinterface

// File: rtl/systema_irq_prio_enc.sv
// systema_irq_prio_enc: lowest-index-first priority encoder producing {any, id}
module systema_irq_prio_enc
  import systema_irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] i_req,
  output logic               o_any,
  output logic [ID_W-1:0]    o_id
);
  assign o_any = |i_req;
  // scan high to low so the lowest set index is the last one written
  always_comb begin
    o_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (i_req[i]) o_id = ID_W'(i);
  end
endmodule

// File: rtl/systema_irq_ctrl.sv
// systema_irq_ctrl: fixed-priority interrupt controller with claim/EOI handshake
// Define SYSTEMA_IRQ_CTRL_EDGE_EN to add the TRIGGER register and edge-mode sources.
module systema_irq_ctrl
  import systema_irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  systema_irq_ctrl_if.slave  bus,
  input  logic [NUM_IRQ-1:0] i_irq_in,
  output logic               o_irq,
  output logic [ID_W-1:0]    o_irq_id
);
  state_t             r_state;
  logic [NUM_IRQ-1:0] r_irq_s, r_en, w_trig, w_pend, w_elig;
  logic               r_gen;
  logic [15:0]        r_rdata, w_rdata;
  logic [ID_W-1:0]    w_win;
  logic               w_any, w_rd, w_wr, w_claim, w_eoi;

  assign w_rd    = bus.chipselect & ~bus.read_n;
  assign w_wr    = bus.chipselect & ~bus.write_n;
  assign w_elig  = w_pend & r_en;
  // a claim only counts while a real winner is being presented to the CPU
  assign w_claim = w_rd && bus.address == ADDR_VECTOR && r_state == S_ASSERT && w_any && r_gen;
  assign w_eoi   = w_wr && bus.address == ADDR_EOI && r_state == S_SERVICE &&
                   bus.writedata[ID_W-1:0] == o_irq_id;
  assign bus.readdata = r_rdata;

  systema_irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_enc (.i_req(w_elig), .o_any(w_any), .o_id(w_win));

`ifdef SYSTEMA_IRQ_CTRL_EDGE_EN
  logic [NUM_IRQ-1:0] r_trig, r_irq_s_d, r_pend_e, w_clr;
  assign w_clr  = (w_wr && bus.address == ADDR_PENDING ? bus.writedata[NUM_IRQ-1:0] : '0) |
                  (w_claim ? NUM_IRQ'(1) << w_win : '0);
  assign w_trig = r_trig;
  assign w_pend = (r_pend_e & r_trig) | (r_irq_s & ~r_trig);
  // edge capture: a rising edge sets pending and wins over a same-cycle clear
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_trig    <= '0;
      r_irq_s_d <= '0;
      r_pend_e  <= '0;
    end else begin
      r_irq_s_d <= r_irq_s;
      if (w_wr && bus.address == ADDR_TRIGGER) r_trig <= bus.writedata[NUM_IRQ-1:0];
      r_pend_e  <= ((r_pend_e & ~w_clr) | (r_irq_s & ~r_irq_s_d)) & r_trig;
    end
`else
  assign w_trig = '0;
  assign w_pend = r_irq_s;
`endif

  // register read mux; VECTOR shows the pre-claim winner only when the claim is honoured
  always_comb begin
    w_rdata = '0;
    case (bus.address)
      ADDR_STATUS:  w_rdata = 16'(r_irq_s);
      ADDR_PENDING: w_rdata = 16'(w_pend);
      ADDR_ENABLE:  w_rdata = 16'(r_en);
      ADDR_TRIGGER: w_rdata = 16'(w_trig);
      ADDR_VECTOR:  w_rdata = w_claim ? (16'(1) << VEC_VALID_BIT) | 16'(w_win) : '0;
      ADDR_CTRL:    w_rdata = {15'd0, r_gen};
      default:      w_rdata = '0;
    endcase
  end

  // input synchroniser, config registers and registered read data
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_irq_s <= '0;
      r_en    <= '0;
      r_gen   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_irq_s <= i_irq_in;
      if (w_rd) r_rdata <= w_rdata;
      if (w_wr && bus.address == ADDR_ENABLE) r_en <= bus.writedata[NUM_IRQ-1:0];
      if (w_wr && bus.address == ADDR_CTRL) r_gen <= bus.writedata[0];
    end

  // IDLE -> ASSERT -> SERVICE handshake; irq_id tracks the winner, then holds the in-service id
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state  <= S_IDLE;
      o_irq    <= 1'b0;
      o_irq_id <= '0;
    end else begin
      case (r_state)
        S_IDLE:
          if (r_gen && w_any) begin
            r_state  <= S_ASSERT;
            o_irq    <= 1'b1;
            o_irq_id <= w_win;
          end
        S_ASSERT:
          if (w_claim) begin
            r_state  <= S_SERVICE;
            o_irq    <= 1'b0;
            o_irq_id <= w_win;
          end else if (!r_gen || !w_any) begin
            r_state <= S_IDLE;
            o_irq   <= 1'b0;
          end else o_irq_id <= w_win;
        S_SERVICE:
          if (w_eoi) r_state <= S_IDLE;
        default: begin
          r_state <= S_IDLE;
          o_irq   <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_systema_irq_ctrl.sv
// tb_systema_irq_ctrl: self-checking bench for the systema interrupt controller
module tb_systema_irq_ctrl;
  import systema_irq_ctrl_pkg::*;
  logic       clk, reset_n, irq;
  logic [7:0] irq_in;
  logic [3:0] irq_id;
  logic [15:0] rd;
  int checks = 0;
  int failures = 0;

  systema_irq_ctrl_if bus_if ();
  systema_irq_ctrl #(.NUM_IRQ(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus_if.slave),
    .i_irq_in(irq_in), .o_irq(irq), .o_irq_id(irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic int lowest(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return -1;
  endfunction

  // all bus tasks start and end on a falling edge; each transfer takes one clock
  task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
    bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0; bus_if.address = a; bus_if.writedata = d;
    @(negedge clk);
    bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [15:0] d);
    bus_if.chipselect = 1'b1; bus_if.read_n = 1'b0; bus_if.address = a;
    @(negedge clk);
    d = bus_if.readdata;
    bus_if.chipselect = 1'b0; bus_if.read_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (irq_id !== 4'd0) begin failures++; $display("FAIL reset_irq_id got=%h exp=0", irq_id); end
    checks++; if (bus_if.readdata !== 16'h0) begin failures++; $display("FAIL reset_readdata got=%h exp=0", bus_if.readdata); end
    reset_n = 1'b1;
    idle(1);
    bus_rd(ADDR_ENABLE, rd);
    checks++; if (rd !== 16'h0) begin failures++; $display("FAIL reset_enable got=%h exp=0", rd); end
    bus_rd(ADDR_CTRL, rd);
    checks++; if (rd !== 16'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", rd); end
    bus_rd(ADDR_TRIGGER, rd);
    checks++; if (rd !== 16'h0) begin failures++; $display("FAIL reset_trigger got=%h exp=0", rd); end
  endtask

  task automatic test_level_timer;
    bus_wr(ADDR_ENABLE, 16'h0001);
    bus_wr(ADDR_CTRL, 16'h0001);
    irq_in = 8'h01;
    idle(1);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL level_irq_early got=%b exp=0", irq); end
    idle(1);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL level_irq_2cyc got=%b exp=1", irq); end
    checks++; if (irq_id !== 4'd0) begin failures++; $display("FAIL level_irq_id got=%h exp=0", irq_id); end
    bus_rd(ADDR_VECTOR, rd);
    checks++; if (rd !== 16'h8000) begin failures++; $display("FAIL level_vector got=%h exp=8000", rd); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL level_claim_drop got=%b exp=0", irq); end
    irq_in = 8'h00;
    idle(2);
    bus_wr(ADDR_EOI, 16'h0000);
    idle(3);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL level_after_eoi got=%b exp=0", irq); end
    bus_rd(ADDR_VECTOR, rd);
    checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL level_idle_vector got=%h exp=0", rd); end
  endtask

  task automatic test_priority;
    bus_wr(ADDR_ENABLE, 16'h00FF);
    irq_in = 8'h24;
    idle(3);
    bus_rd(ADDR_VECTOR, rd);
    checks++; if (rd !== 16'h8002) begin failures++; $display("FAIL prio_first got=%h exp=8002", rd); end
    irq_in = 8'h20;
    idle(2);
    bus_wr(ADDR_EOI, 16'h0002);
    idle(2);
    checks++; if (irq !== 1'b1 || irq_id !== 4'd5) begin failures++; $display("FAIL prio_reassert got=%b/%h exp=1/5", irq, irq_id); end
    bus_rd(ADDR_VECTOR, rd);
    checks++; if (rd !== 16'h8005) begin failures++; $display("FAIL prio_second got=%h exp=8005", rd); end
    irq_in = 8'h00;
    idle(2);
    bus_wr(ADDR_EOI, 16'h0005);
    idle(2);
  endtask

  task automatic test_masking;
    bus_wr(ADDR_ENABLE, 16'h0000);
    irq_in = 8'h08;
    idle(3);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mask_en_irq got=%b exp=0", irq); end
    bus_rd(ADDR_VECTOR, rd);
    checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL mask_en_vector got=%h exp=0", rd); end
    bus_wr(ADDR_CTRL, 16'h0000);
    bus_wr(ADDR_ENABLE, 16'h0008);
    idle(3);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mask_ctrl_irq got=%b exp=0", irq); end
    bus_rd(ADDR_VECTOR, rd);
    checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL mask_ctrl_vector got=%h exp=0", rd); end
    bus_wr(ADDR_CTRL, 16'h0001);
    idle(2);
    checks++; if (irq !== 1'b1 || irq_id !== 4'd3) begin failures++; $display("FAIL mask_assert got=%b/%h exp=1/3", irq, irq_id); end
    bus_wr(ADDR_ENABLE, 16'h0000);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL mask_hold got=%b exp=1", irq); end
    idle(1);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mask_drop got=%b exp=0", irq); end
    irq_in = 8'h00;
    idle(2);
  endtask

  task automatic test_misuse;
    bus_wr(ADDR_ENABLE, 16'h0002);
    irq_in = 8'h02;
    idle(3);
    bus_rd(ADDR_VECTOR, rd);
    checks++; if (rd !== 16'h8001) begin failures++; $display("FAIL misuse_claim got=%h exp=8001", rd); end
    bus_wr(ADDR_EOI, 16'h0003);
    idle(3);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL misuse_bad_eoi got=%b exp=0", irq); end
    checks++; if (irq_id !== 4'd1) begin failures++; $display("FAIL misuse_isr_id got=%h exp=1", irq_id); end
    bus_rd(ADDR_VECTOR, rd);
    checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL misuse_nested got=%h exp=0", rd); end
    irq_in = 8'h00;
    idle(2);
    bus_wr(ADDR_EOI, 16'h0001);
    idle(3);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL misuse_final got=%b exp=0", irq); end
  endtask

`ifdef SYSTEMA_IRQ_CTRL_EDGE_EN
  task automatic test_edge;
    bus_wr(ADDR_TRIGGER, 16'h0002);
    bus_wr(ADDR_ENABLE, 16'h0002);
    irq_in = 8'h02;
    idle(1);
    irq_in = 8'h00;
    idle(1);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL edge_irq_early got=%b exp=0", irq); end
    idle(1);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL edge_irq_3cyc got=%b exp=1", irq); end
    bus_rd(ADDR_PENDING, rd);
    checks++; if (rd !== 16'h0002) begin failures++; $display("FAIL edge_pending got=%h exp=0002", rd); end
    bus_rd(ADDR_VECTOR, rd);
    checks++; if (rd !== 16'h8001) begin failures++; $display("FAIL edge_claim got=%h exp=8001", rd); end
    bus_rd(ADDR_PENDING, rd);
    checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL edge_claim_clear got=%h exp=0", rd); end
    bus_wr(ADDR_EOI, 16'h0001);
    idle(3);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL edge_after_eoi got=%b exp=0", irq); end
    bus_wr(ADDR_ENABLE, 16'h0000);
    irq_in = 8'h02;
    idle(1);
    irq_in = 8'h00;
    idle(3);
    bus_rd(ADDR_PENDING, rd);
    checks++; if (rd !== 16'h0002) begin failures++; $display("FAIL edge_pend_set got=%h exp=0002", rd); end
    irq_in = 8'h02;
    idle(1);
    bus_wr(ADDR_PENDING, 16'h0002);
    irq_in = 8'h00;
    idle(2);
    bus_rd(ADDR_PENDING, rd);
    checks++; if (rd !== 16'h0002) begin failures++; $display("FAIL edge_set_wins got=%h exp=0002", rd); end
    bus_wr(ADDR_PENDING, 16'h0002);
    bus_rd(ADDR_PENDING, rd);
    checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL edge_w1c got=%h exp=0", rd); end
    bus_wr(ADDR_TRIGGER, 16'h0000);
    idle(2);
  endtask
`else
  task automatic test_edge;
    bus_wr(ADDR_TRIGGER, 16'h00FF);
    bus_rd(ADDR_TRIGGER, rd);
    checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL noedge_trigger got=%h exp=0", rd); end
    irq_in = 8'h10;
    idle(2);
    bus_wr(ADDR_PENDING, 16'h0010);
    bus_rd(ADDR_PENDING, rd);
    checks++; if (rd !== 16'h0010) begin failures++; $display("FAIL noedge_w1c got=%h exp=0010", rd); end
    irq_in = 8'h00;
    idle(2);
    bus_rd(ADDR_PENDING, rd);
    checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL noedge_level_follow got=%h exp=0", rd); end
  endtask
`endif

  task automatic test_random;
    logic [7:0] en, lines;
    int lo;
    for (int k = 0; k < 12; k++) begin
      en = 8'($urandom_range(0, 255));
      lines = 8'($urandom_range(0, 255));
      lo = lowest({8'h00, en & lines});
      bus_wr(ADDR_ENABLE, {8'h00, en});
      bus_rd(ADDR_ENABLE, rd);
      checks++; if (rd !== {8'h00, en}) begin failures++; $display("FAIL rand_enable[%0d] got=%h exp=%h", k, rd, en); end
      irq_in = lines;
      idle(3);
      bus_rd(ADDR_STATUS, rd);
      checks++; if (rd !== {8'h00, lines}) begin failures++; $display("FAIL rand_status[%0d] got=%h exp=%h", k, rd, lines); end
      checks++; if (irq !== (lo >= 0)) begin failures++; $display("FAIL rand_irq[%0d] got=%b exp=%b", k, irq, lo >= 0); end
      if (lo >= 0) begin
        checks++; if (irq_id !== 4'(lo)) begin failures++; $display("FAIL rand_id[%0d] got=%h exp=%h", k, irq_id, lo); end
      end
      bus_rd(ADDR_VECTOR, rd);
      checks++; if (rd !== (lo >= 0 ? 16'h8000 | 16'(lo) : 16'h0000)) begin
        failures++; $display("FAIL rand_vector[%0d] got=%h en=%h lines=%h", k, rd, en, lines);
      end
      irq_in = 8'h00;
      idle(2);
      if (lo >= 0) bus_wr(ADDR_EOI, 16'(lo));
      idle(2);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rand_idle[%0d] got=%b exp=0", k, irq); end
    end
  endtask

  task automatic test_reset_mid_service;
    bus_wr(ADDR_ENABLE, 16'h0001);
    bus_wr(ADDR_CTRL, 16'h0001);
    irq_in = 8'h01;
    idle(3);
    bus_rd(ADDR_VECTOR, rd);
    checks++; if (rd !== 16'h8000) begin failures++; $display("FAIL rst_claim got=%h exp=8000", rd); end
    #3 reset_n = 1'b0;
    #1;
    checks++; if (irq !== 1'b0 || irq_id !== 4'd0 || bus_if.readdata !== 16'h0) begin
      failures++; $display("FAIL rst_async got irq=%b id=%h rd=%h exp=0/0/0", irq, irq_id, bus_if.readdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus_rd(ADDR_ENABLE, rd);
    checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL rst_enable got=%h exp=0", rd); end
    bus_rd(ADDR_CTRL, rd);
    checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL rst_ctrl got=%h exp=0", rd); end
    idle(2);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", irq); end
    bus_rd(ADDR_STATUS, rd);
    checks++; if (rd !== 16'h0001) begin failures++; $display("FAIL rst_status1 got=%h exp=0001", rd); end
    irq_in = 8'h05;
    idle(2);
    bus_rd(ADDR_STATUS, rd);
    checks++; if (rd !== 16'h0005) begin failures++; $display("FAIL rst_status5 got=%h exp=0005", rd); end
  endtask

  initial begin
    reset_n = 1'b0;
    irq_in = 8'h00;
    bus_if.chipselect = 1'b0;
    bus_if.read_n = 1'b1;
    bus_if.write_n = 1'b1;
    bus_if.address = 3'd0;
    bus_if.writedata = 16'h0;
    idle(3);
    test_reset;
    test_level_timer;
    test_priority;
    test_masking;
    test_misuse;
    test_edge;
    bus_wr(ADDR_CTRL, 16'h0001);
    test_random;
    test_reset_mid_service;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
